// File: rtl/timer_sched_pkg.sv
// Shared constants for the CoreTimer APB scheduler: timer register word indices,
// register values and FSM state encodings.
package timer_sched_pkg;

    localparam logic [2:0] REG_LOAD   = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_PRESC  = 3'd3;
    localparam logic [2:0] REG_INTCLR = 3'd4;

    localparam logic [31:0] CTRL_ONESHOT_RUN = 32'h0000_0007;
    localparam logic [31:0] CTRL_OFF         = 32'h0000_0000;
    localparam logic [31:0] INTCLR_VAL       = 32'h0000_0001;

    localparam logic [3:0] ST_INIT_DIS = 4'd0;
    localparam logic [3:0] ST_INIT_CLR = 4'd1;
    localparam logic [3:0] ST_IDLE     = 4'd2;
    localparam logic [3:0] ST_W_PRESC  = 4'd3;
    localparam logic [3:0] ST_W_LOAD   = 4'd4;
    localparam logic [3:0] ST_W_CTRL   = 4'd5;
    localparam logic [3:0] ST_WAIT_INT = 4'd6;
    localparam logic [3:0] ST_W_DIS    = 4'd7;
    localparam logic [3:0] ST_W_CLR    = 4'd8;
    localparam logic [3:0] ST_DONE     = 4'd9;

    // States that own exactly one APB write (SETUP + ACCESS)
    function automatic logic is_wr_state(input logic [3:0] st);
        logic wr_v;
        case (st)
            ST_INIT_DIS, ST_INIT_CLR, ST_W_PRESC, ST_W_LOAD,
            ST_W_CTRL, ST_W_DIS, ST_W_CLR: wr_v = 1'b1;
            default:                       wr_v = 1'b0;
        endcase
        return wr_v;
    endfunction

endpackage

// File: rtl/apb_wr_master.sv
// Zero-wait-state APB write master: a start launches SETUP then ACCESS; a start
// seen in the ACCESS cycle chains the next SETUP back to back.
module apb_wr_master (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        start,
    input  logic [2:0]  addr,
    input  logic [31:0] data,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [2:0]  paddr,
    output logic [31:0] pwdata,
    output logic        xfer_done
);

    logic        psel_r;
    logic        penable_r;
    logic [2:0]  paddr_r;
    logic [31:0] pwdata_r;

    // APB phase sequencing and address/data capture
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            paddr_r   <= 3'd0;
            pwdata_r  <= 32'd0;
        end else if (start && (!psel_r || penable_r)) begin
            psel_r    <= 1'b1;
            penable_r <= 1'b0;
            paddr_r   <= addr;
            pwdata_r  <= data;
        end else if (psel_r && !penable_r) begin
            penable_r <= 1'b1;
        end else begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
        end
    end

    assign psel      = psel_r;
    assign penable   = penable_r;
    assign pwrite    = psel_r;
    assign paddr     = paddr_r;
    assign pwdata    = pwdata_r;
    assign xfer_done = psel_r & penable_r;

endmodule

// File: rtl/timer_apb_scheduler.sv
// Round-robin scheduler sharing one CoreTimer among N_REQ requesters over APB.
// Optional feature macro: TIMER_SCHED_CANCEL_EN adds cancel/cancelled ports.
module timer_apb_scheduler
    import timer_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     req_load,
    input  logic [3:0]                 cfg_prescale,
`ifdef TIMER_SCHED_CANCEL_EN
    input  logic [N_REQ-1:0]           cancel,
    output logic [N_REQ-1:0]           cancelled,
`endif
    output logic [N_REQ-1:0]           done,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic [2:0]                 M_PADDR,
    output logic                       M_PSEL,
    output logic                       M_PENABLE,
    output logic                       M_PWRITE,
    output logic [31:0]                M_PWDATA,
    input  logic                       TIMINT
);

    localparam int IDW  = $clog2(N_REQ);
    localparam int IDW1 = IDW + 1;

    logic [3:0]       state_r;
    logic [3:0]       next_state_s;
    logic [IDW-1:0]   rr_ptr_r;
    logic [IDW-1:0]   grant_id_r;
    logic             busy_r;
    logic [N_REQ-1:0] done_r;
    logic             arb_found_s;
    logic [IDW-1:0]   arb_idx_s;
    logic [IDW:0]     cand_v;
    logic             arb_zero_s;
    logic [WIDTH-1:0] grant_load_s;
    logic [IDW-1:0]   done_id_s;
    logic             wr_start_s;
    logic [2:0]       wr_addr_s;
    logic [31:0]      wr_data_s;
    logic             xfer_done_s;
    logic             cancel_any_s;

    // Round-robin search: lowest index at or after rr_ptr_r, wrapping
    always_comb begin
        arb_found_s = |req;
        arb_idx_s   = '0;
        cand_v      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand_v    = {1'b0, rr_ptr_r} + IDW1'(k);
            cand_v    = (cand_v >= IDW1'(N_REQ)) ? (cand_v - IDW1'(N_REQ)) : cand_v;
            arb_idx_s = req[cand_v[IDW-1:0]] ? cand_v[IDW-1:0] : arb_idx_s;
        end
    end

    assign arb_zero_s   = (req_load[int'(arb_idx_s)*WIDTH +: WIDTH] == '0);
    assign grant_load_s = req_load[int'(grant_id_r)*WIDTH +: WIDTH];
    assign done_id_s    = (state_r == ST_IDLE) ? arb_idx_s : grant_id_r;

`ifdef TIMER_SCHED_CANCEL_EN
    logic             cancel_pend_r;
    logic             cancel_hit_s;
    logic [N_REQ-1:0] cancelled_r;

    assign cancel_hit_s = cancel[grant_id_r] && (state_r >= ST_W_PRESC) && (state_r <= ST_WAIT_INT);
    assign cancel_any_s = cancel_hit_s || cancel_pend_r;

    // Remember a cancel until DONE; a same-cycle expiry in WAIT_INT takes precedence
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cancel_pend_r <= 1'b0;
            cancelled_r   <= '0;
        end else begin
            if (state_r == ST_DONE) begin
                cancel_pend_r <= 1'b0;
            end else if (cancel_hit_s && !((state_r == ST_WAIT_INT) && TIMINT)) begin
                cancel_pend_r <= 1'b1;
            end
            cancelled_r <= ((next_state_s == ST_DONE) && cancel_pend_r) ? (N_REQ'(1) << grant_id_r) : '0;
        end
    end

    assign cancelled = cancelled_r;
`else
    assign cancel_any_s = 1'b0;
`endif

    // FSM next state
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_INIT_DIS: next_state_s = xfer_done_s ? ST_INIT_CLR : ST_INIT_DIS;
            ST_INIT_CLR: next_state_s = xfer_done_s ? ST_IDLE : ST_INIT_CLR;
            ST_IDLE: begin
                if (arb_found_s) begin
                    next_state_s = arb_zero_s ? ST_DONE : ST_W_PRESC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_W_PRESC: next_state_s = xfer_done_s ? (cancel_any_s ? ST_W_DIS : ST_W_LOAD) : ST_W_PRESC;
            ST_W_LOAD:  next_state_s = xfer_done_s ? (cancel_any_s ? ST_W_DIS : ST_W_CTRL) : ST_W_LOAD;
            ST_W_CTRL:  next_state_s = xfer_done_s ? (cancel_any_s ? ST_W_DIS : ST_WAIT_INT) : ST_W_CTRL;
            ST_WAIT_INT: next_state_s = (TIMINT || cancel_any_s) ? ST_W_DIS : ST_WAIT_INT;
            ST_W_DIS:   next_state_s = xfer_done_s ? ST_W_CLR : ST_W_DIS;
            ST_W_CLR:   next_state_s = xfer_done_s ? ST_DONE : ST_W_CLR;
            ST_DONE:    next_state_s = ST_IDLE;
            default:    next_state_s = ST_INIT_DIS;
        endcase
    end

    // Write launch is decoded from the next state so SETUP starts on the state's first cycle
    always_comb begin
        wr_start_s = is_wr_state(next_state_s) && ((next_state_s != state_r) || !M_PSEL);
        wr_addr_s  = REG_CTRL;
        wr_data_s  = CTRL_OFF;
        case (next_state_s)
            ST_INIT_DIS, ST_W_DIS: begin
                wr_addr_s = REG_CTRL;
                wr_data_s = CTRL_OFF;
            end
            ST_INIT_CLR, ST_W_CLR: begin
                wr_addr_s = REG_INTCLR;
                wr_data_s = INTCLR_VAL;
            end
            ST_W_PRESC: begin
                wr_addr_s = REG_PRESC;
                wr_data_s = {28'h0, cfg_prescale};
            end
            ST_W_LOAD: begin
                wr_addr_s = REG_LOAD;
                wr_data_s = 32'(grant_load_s);
            end
            ST_W_CTRL: begin
                wr_addr_s = REG_CTRL;
                wr_data_s = CTRL_ONESHOT_RUN;
            end
            default: begin
                wr_addr_s = REG_CTRL;
                wr_data_s = CTRL_OFF;
            end
        endcase
    end

    // State, arbitration pointer and registered status outputs
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r    <= ST_INIT_DIS;
            rr_ptr_r   <= '0;
            grant_id_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= '0;
        end else begin
            state_r <= next_state_s;
            if ((state_r == ST_IDLE) && arb_found_s) begin
                grant_id_r <= arb_idx_s;
                rr_ptr_r   <= (arb_idx_s == IDW'(N_REQ - 1)) ? '0 : (arb_idx_s + IDW'(1));
            end
            busy_r <= (next_state_s >= ST_W_PRESC) && (next_state_s <= ST_W_CLR);
            done_r <= (next_state_s == ST_DONE) ? (N_REQ'(1) << done_id_s) : '0;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign grant_id = grant_id_r;

    apb_wr_master u_apb (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .start     (wr_start_s),
        .addr      (wr_addr_s),
        .data      (wr_data_s),
        .psel      (M_PSEL),
        .penable   (M_PENABLE),
        .pwrite    (M_PWRITE),
        .paddr     (M_PADDR),
        .pwdata    (M_PWDATA),
        .xfer_done (xfer_done_s)
    );

endmodule

// File: tb/tb_timer_apb_scheduler.sv
// Directed bench for timer_apb_scheduler; APB writes are logged and compared to
// hand-computed sequences. Cancel checks build only with TIMER_SCHED_CANCEL_EN.
module tb_timer_apb_scheduler;

    logic         PCLK = 1'b0;
    logic         PRESETn = 1'b0;
    logic [3:0]   req = 4'h0;
    logic [127:0] req_load = 128'h0;
    logic [3:0]   cfg_prescale = 4'h0;
    logic [3:0]   done;
    logic         busy;
    logic [1:0]   grant_id;
    logic [2:0]   M_PADDR;
    logic         M_PSEL, M_PENABLE, M_PWRITE;
    logic [31:0]  M_PWDATA;
    logic         TIMINT;
    logic         auto_int = 1'b0;
    logic         man_int = 1'b0;
    logic         tmr_auto = 1'b1;
`ifdef TIMER_SCHED_CANCEL_EN
    logic [3:0]   cancel = 4'h0;
    logic [3:0]   cancelled;
`endif

    typedef struct {
        logic [2:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;

    wr_t wr_q[$];
    int  cyc_cnt = 0;
    int  done_cnt = 0;
    int  tcnt = 0;
    int  n_chk = 0;
    int  n_fail = 0;

    assign TIMINT = auto_int | man_int;

    timer_apb_scheduler #(.N_REQ(4), .WIDTH(32)) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .req          (req),
        .req_load     (req_load),
        .cfg_prescale (cfg_prescale),
`ifdef TIMER_SCHED_CANCEL_EN
        .cancel       (cancel),
        .cancelled    (cancelled),
`endif
        .done         (done),
        .busy         (busy),
        .grant_id     (grant_id),
        .M_PADDR      (M_PADDR),
        .M_PSEL       (M_PSEL),
        .M_PENABLE    (M_PENABLE),
        .M_PWRITE     (M_PWRITE),
        .M_PWDATA     (M_PWDATA),
        .TIMINT       (TIMINT)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc_cnt <= cyc_cnt + 1;

    // Bus monitor, done counter and a simple one-shot timer model
    always @(negedge PCLK) begin
        if (M_PSEL && M_PENABLE) wr_q.push_back('{a: M_PADDR, d: M_PWDATA, c: cyc_cnt});
        done_cnt <= done_cnt + $countones(done);
        if (M_PSEL && M_PENABLE && M_PADDR == 3'd2 && M_PWDATA == 32'h7) tcnt <= 3;
        else if (tcnt > 0) tcnt <= tcnt - 1;
        auto_int <= tmr_auto && (tcnt == 1);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge PCLK);
            #1;
        end
    endtask

    task automatic expect_wr(input string tag, input int idx, input logic [2:0] ea, input logic [31:0] ed);
        if (idx < wr_q.size()) check_eq(tag, {29'h0, wr_q[idx].a, wr_q[idx].d}, {29'h0, ea, ed});
        else check_eq({tag, "_missing"}, 64'hFFFF_FFFF_FFFF_FFFF, {29'h0, ea, ed});
    endtask

    task automatic wait_done(input int budget, output logic [3:0] d, output logic [3:0] cx);
        d  = 4'h0;
        cx = 4'h0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (done != 4'h0) begin
                d = done;
`ifdef TIMER_SCHED_CANCEL_EN
                cx = cancelled;
`endif
                break;
            end
        end
    endtask

    task automatic wait_wr_count(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (wr_q.size() >= n) break;
            tick(1);
        end
    endtask

    task automatic check_init(input string tag);
        int c0;
        wr_q.delete();
        c0 = cyc_cnt;
        PRESETn = 1'b1;
        tick(8);
        check_eq({tag, "_nwr"}, 64'(wr_q.size()), 64'd2);
        expect_wr({tag, "_dis"}, 0, 3'd2, 32'h0);
        expect_wr({tag, "_clr"}, 1, 3'd4, 32'h1);
        if (wr_q.size() >= 2) begin
            check_eq({tag, "_dis_cyc"}, 64'(wr_q[0].c - c0), 64'd2);
            check_eq({tag, "_clr_cyc"}, 64'(wr_q[1].c - c0), 64'd4);
        end
        check_eq({tag, "_idle"}, {62'h0, busy, M_PSEL}, 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] d, cx;
        int c0, d0, found;

        // Reset values, then the timer quiesce sequence
        tick(3);
        check_eq("reset_outs", {19'h0, M_PSEL, M_PENABLE, M_PWRITE, busy, done, grant_id, M_PADDR, M_PWDATA},
                 64'h0);
        check_init("init");

        // All four requesting from rr_ptr 0: grants 0,1,2,3,0
        for (int i = 0; i < 4; i++) req_load[i*32 +: 32] = 32'(10 + i);
        d0 = done_cnt;
        wr_q.delete();
        req = 4'hF;
        for (int g = 0; g < 5; g++) begin
            wait_done(60, d, cx);
            check_eq($sformatf("rr_done%0d", g), 64'(d), 64'(4'h1 << (g % 4)));
            check_eq($sformatf("rr_gid%0d", g), 64'(grant_id), 64'(g % 4));
            check_eq($sformatf("rr_nwr%0d", g), 64'(wr_q.size()), 64'd5);
            expect_wr($sformatf("rr_load%0d", g), 1, 3'd0, 32'(10 + (g % 4)));
            wr_q.delete();
            if (g == 4) req = 4'h0;
        end
        tick(10);
        check_eq("rr_done_total", 64'(done_cnt - d0), 64'd5);

        // Single request, manual interrupt, full write sequence and latency
        tmr_auto = 1'b0;
        req_load[1*32 +: 32] = 32'd5;
        cfg_prescale = 4'h0;
        wr_q.delete();
        c0 = cyc_cnt;
        req = 4'b0010;
        check_eq("r1_busy_grant", 64'(busy), 64'd0);
        tick(1);
        check_eq("r1_busy_after", 64'(busy), 64'd1);
        tick(8);
        check_eq("r1_nwr", 64'(wr_q.size()), 64'd3);
        expect_wr("r1_presc", 0, 3'd3, 32'h0);
        expect_wr("r1_load", 1, 3'd0, 32'd5);
        expect_wr("r1_ctrl", 2, 3'd2, 32'h7);
        if (wr_q.size() >= 3) check_eq("r1_ctrl_cyc", 64'(wr_q[2].c - c0), 64'd6);
        check_eq("r1_waiting", {59'h0, busy, done}, {59'h0, 1'b1, 4'h0});
        wr_q.delete();
        man_int = 1'b1;
        tick(1);
        man_int = 1'b0;
        wait_done(20, d, cx);
        req = 4'h0;
        check_eq("r1_done", 64'(d), 64'h2);
        check_eq("r1_busy_done", 64'(busy), 64'd0);
        expect_wr("r1_dis", 0, 3'd2, 32'h0);
        expect_wr("r1_clr", 1, 3'd4, 32'h1);

        // Interrupt while idle is ignored
        d0 = done_cnt;
        wr_q.delete();
        tick(2);
        man_int = 1'b1;
        tick(1);
        man_int = 1'b0;
        tick(5);
        check_eq("stray_int", {32'(wr_q.size()), 32'(done_cnt - d0)}, 64'h0);

        // Zero load: done one cycle after grant, no bus traffic
        req_load[2*32 +: 32] = 32'h0;
        d0 = done_cnt;
        wr_q.delete();
        req = 4'b0100;
        check_eq("z_done_grant", 64'(done), 64'h0);
        tick(1);
        check_eq("z_done", {58'h0, busy, done, grant_id}, {58'h0, 1'b0, 4'b0100, 2'd2});
        req = 4'h0;
        tick(5);
        check_eq("z_nwr", 64'(wr_q.size()), 64'd0);
        check_eq("z_done_total", 64'(done_cnt - d0), 64'd1);

        // Reset in the Load ACCESS cycle
        req_load[3*32 +: 32] = 32'd9;
        req = 4'b1000;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (M_PSEL && M_PENABLE && M_PADDR == 3'd0) begin
                found = 1;
                break;
            end
        end
        check_eq("rst_reach_load", 64'(found), 64'd1);
        PRESETn = 1'b0;
        #1;
        check_eq("rst_drop", {61'h0, M_PSEL, M_PENABLE, busy}, 64'h0);
        req = 4'h0;
        tick(2);
        check_init("reinit");

`ifdef TIMER_SCHED_CANCEL_EN
        // Cancel in WAIT_INT, non-owner cancel ignored
        req_load[0*32 +: 32] = 32'd7;
        wr_q.delete();
        req = 4'b0001;
        wait_wr_count(3, 20);
        tick(2);
        d0 = done_cnt;
        cancel = 4'b0100;
        tick(1);
        cancel = 4'h0;
        tick(3);
        check_eq("c_other_ignored", {32'(wr_q.size()), 32'(done_cnt - d0)}, {32'd3, 32'd0});
        cancel = 4'b0001;
        tick(1);
        cancel = 4'h0;
        wait_done(20, d, cx);
        req = 4'h0;
        check_eq("c_done", {56'h0, d, cx}, {56'h0, 4'h1, 4'h1});
        expect_wr("c_dis", 3, 3'd2, 32'h0);
        expect_wr("c_clr", 4, 3'd4, 32'h1);

        // Cancel together with expiry: expiry wins
        tick(2);
        wr_q.delete();
        req = 4'b0001;
        wait_wr_count(3, 20);
        tick(2);
        cancel = 4'b0001;
        man_int = 1'b1;
        tick(1);
        cancel = 4'h0;
        man_int = 1'b0;
        wait_done(20, d, cx);
        req = 4'h0;
        check_eq("c_expiry_wins", {56'h0, d, cx}, {56'h0, 4'h1, 4'h0});
        tick(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
